rgb_color_sequencer: RTL and testbench
======================================

Name: rgb_color_sequencer

Overview:
- Parametrised successor of the single-byte RGB colour cycler.
- Button 0 steps through a palette of NCOLORS entries; button 1 held forces a default colour.
- Adds button synchronisation and debounce, palette depth/channel width parameters, and an optional linear fade toward the target colour.
- Drives the packed RGB word consumed by the LED PWM stage.

Parameters:
- CW, 8: bits per colour channel, range 4..16.
- NCOLORS, 4: palette depth, range 2..8.
- DB_CYCLES, 16: consecutive stable cycles required to accept a button level change, minimum 1.
- FADE_DIV, 0: clk cycles per one-LSB fade step. 0 = no fade; output tracks target with 1-cycle latency.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- button  in  2  raw buttons, asynchronous. [0] = next colour, [1] = default override, held.
- RGBcolor  out  3*CW  packed output {red, green, blue}, each CW bits.
- color_idx  out  3  current palette index, zero-extended.
- settled  out  1  high when RGBcolor equals the current target.

Behaviour:
- Reset (async, active-high):
  - RGBcolor = 0, color_idx = 0, settled = 0.
  - Synchronisers, debounce counters and debounced levels all 0.
  - Fade prescaler = 0.
- Level constants:
  - H = 2^(CW-1)-1.
  - Q = 2^(CW-2)-1.
  - D = 3*2^(CW-3)-1. For CW=8: H=0x7F, Q=0x3F, D=0x5F.
- Palette, as {R,G,B}:
  - idx0 = {Q,Q,Q}, idx1 = {H,0,0}, idx2 = {0,H,0}, idx3 = {0,0,H}.
  - idx4 = {H,H,0}, idx5 = {0,H,H}, idx6 = {H,0,H}, idx7 = {H,H,H}.
  - Only idx 0..NCOLORS-1 are reachable.
- Input path, per button:
  - Two-flop synchroniser produces s.
  - Debounced level b flips only after s != b for DB_CYCLES consecutive cycles.
  - The counter clears whenever s == b; a glitch shorter than DB_CYCLES never changes b.
- Index:
  - On a rising edge of b0 (b0=1, previous b0=0), color_idx increments one cycle later.
  - NCOLORS-1 wraps to 0.
  - Falling edges of b0 are ignored.
  - The index still advances while b1 is held; the advanced colour appears on release.
- Target (combinational):
  - b1 = 1 gives {D,D,D}.
  - Otherwise palette[color_idx].
  - Override has priority over a simultaneous b0 edge; that edge is still counted.
- Output with FADE_DIV = 0:
  - RGBcolor <= target every cycle.
  - Output appears one cycle after color_idx/b1 change.
  - settled = (RGBcolor == target), registered with RGBcolor.
- Output with FADE_DIV > 0:
  - The prescaler counts 0..FADE_DIV-1 and wraps.
  - On the wrap cycle, each channel independently moves one LSB toward its target: +1 if below, -1 if above, hold if equal.
  - Channels never overshoot.
  - A target change mid-fade redirects immediately from the current value; there is no restart or jump.
  - settled = 1 only when all three channels equal target.
- Latency from a raw button[0] edge to the RGBcolor change, FADE_DIV = 0:
  - 2 cycles synchroniser, then DB_CYCLES debounce, then 1 cycle b0, then 1 cycle idx, then 1 cycle RGBcolor.
  - Total DB_CYCLES + 5 clk edges, ±1 for sampling phase.
- After reset release, outputs ramp or step from 0 toward idx0 {Q,Q,Q}.
- Reset asserted mid-fade or mid-debounce returns every register to its reset value immediately; no pending edge survives.

Test Plan:
- Reset, CW=8, FADE_DIV=0, no buttons -> RGBcolor=0 during reset; 0x3F3F3F one cycle after release; color_idx=0, settled=1.
- NCOLORS=4, DB_CYCLES=16: four clean presses of button[0] (held 40 cycles, gap 40) -> sequence 0x7F0000, 0x007F00, 0x00007F, 0x3F3F3F; color_idx 1,2,3,0 (wrap).
- DB_CYCLES=16: 10-cycle pulse on button[0], then bouncy press (5 toggles of 3 cycles, then stable) -> no change from the pulse; exactly one index increment from the bouncy press.
- button[1] held at idx2 -> 0x5F5F5F while held; button[0] press during hold -> output stays 0x5F5F5F; release -> 0x00007F (idx3).
- FADE_DIV=4, idx0 -> idx1 -> red rises 0x3F->0x7F and green/blue fall 0x3F->0x00, one LSB per 4 cycles; settled=0 throughout; settled=1 after 64 steps (256 cycles) at 0x7F0000.
- FADE_DIV=4: press button[1] mid-fade, then assert rst mid-fade -> channels redirect toward 0x5F without jump; rst forces RGBcolor=0, color_idx=0, settled=0 asynchronously.

Source files
------------

// File: rtl/rgb_color_sequencer.sv
`default_nettype none
// ============================================================================
// rgb_color_sequencer : debounced two-button palette sequencer, optional fade
// Rev 1.0
// ============================================================================
module rgb_color_sequencer #(
  parameter int CW        = 8,
  parameter int NCOLORS   = 4,
  parameter int DB_CYCLES = 16,
  parameter int FADE_DIV  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      button,
  output logic [3*CW-1:0] RGBcolor,
  output logic [2:0]      color_idx,
  output logic            settled
);

  localparam int            DBW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_Z = '0;
  localparam logic [CW-1:0] C_H = CW'((1 << (CW - 1)) - 1);
  localparam logic [CW-1:0] C_Q = CW'((1 << (CW - 2)) - 1);
  localparam logic [CW-1:0] C_D = CW'(3 * (1 << (CW - 3)) - 1);

  function automatic logic [3*CW-1:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = {C_Q, C_Q, C_Q};
      3'd1:    palette = {C_H, C_Z, C_Z};
      3'd2:    palette = {C_Z, C_H, C_Z};
      3'd3:    palette = {C_Z, C_Z, C_H};
      3'd4:    palette = {C_H, C_H, C_Z};
      3'd5:    palette = {C_Z, C_H, C_H};
      3'd6:    palette = {C_H, C_Z, C_H};
      default: palette = {C_H, C_H, C_H};
    endcase
  endfunction

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      btn_lvl;
  logic            b0_prev_q;
  logic [2:0]      idx_q, idx_d;
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic            settled_q;
  logic [3*CW-1:0] target;

  // Level only moves after DB_CYCLES consecutive disagreeing samples.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [DBW-1:0] cnt_q;
    logic           lvl_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (sync2_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[g];
      end else begin
        cnt_q <= cnt_q + DBW'(1);
      end
    end
    assign btn_lvl[g] = lvl_q;
  end

  always_comb begin
    idx_d = idx_q;
    if (btn_lvl[0] && !b0_prev_q)
      idx_d = (idx_q == 3'(NCOLORS - 1)) ? 3'd0 : idx_q + 3'd1;
  end

  assign target = btn_lvl[1] ? {C_D, C_D, C_D} : palette(idx_q);

  if (FADE_DIV == 0) begin : g_nofade
    assign rgb_d = target;
  end else begin : g_fade
    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    logic [PW-1:0] pre_q;
    logic          wrap;

    assign wrap = (pre_q == PW'(FADE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pre_q <= '0;
      else     pre_q <= wrap ? '0 : pre_q + PW'(1);
    end

    // Each channel walks one LSB toward its own target on the wrap cycle.
    always_comb begin
      rgb_d = rgb_q;
      if (wrap) begin
        for (int c = 0; c < 3; c++) begin
          if (rgb_q[c*CW +: CW] < target[c*CW +: CW])
            rgb_d[c*CW +: CW] = rgb_q[c*CW +: CW] + CW'(1);
          else if (rgb_q[c*CW +: CW] > target[c*CW +: CW])
            rgb_d[c*CW +: CW] = rgb_q[c*CW +: CW] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      b0_prev_q <= 1'b0;
      idx_q     <= '0;
      rgb_q     <= '0;
      settled_q <= 1'b0;
    end else begin
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      b0_prev_q <= btn_lvl[0];
      idx_q     <= idx_d;
      rgb_q     <= rgb_d;
      settled_q <= (rgb_d == target);
    end
  end

  assign RGBcolor  = rgb_q;
  assign color_idx = idx_q;
  assign settled   = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_color_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rgb_color_sequencer : random + directed bench, step and fade instances
// Rev 1.0
// ============================================================================
module tb_rgb_color_sequencer;

  localparam int N  = 4;
  localparam int DB = 16;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  button = 2'b00;
  logic [23:0] rgb0, rgb4;
  logic [2:0]  idx0, idx4;
  logic        set0, set4;

  always #5 clk = ~clk;

  rgb_color_sequencer #(.CW(8), .NCOLORS(N), .DB_CYCLES(DB), .FADE_DIV(0)) u_step (
    .clk(clk), .rst(rst), .button(button),
    .RGBcolor(rgb0), .color_idx(idx0), .settled(set0)
  );

  rgb_color_sequencer #(.CW(8), .NCOLORS(N), .DB_CYCLES(DB), .FADE_DIV(FD)) u_fade (
    .clk(clk), .rst(rst), .button(button),
    .RGBcolor(rgb4), .color_idx(idx4), .settled(set4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: colours straight from the palette table, button path as
  // a two-sample delay line followed by a run-length filter.
  int         pal [8] = '{'h3F3F3F, 'h7F0000, 'h007F00, 'h00007F,
                          'h7F7F00, 'h007F7F, 'h7F007F, 'h7F7F7F};
  localparam int OVR = 'h5F5F5F;

  logic [1:0] m_dly[$] = '{2'b00, 2'b00};
  int         m_run [2] = '{0, 0};
  logic [1:0] m_lvl = 2'b00;
  logic       m_prev0 = 1'b0;
  int         m_idx = 0;
  int         m_rgb0 = 0, m_rgb4 = 0;
  logic       m_set0 = 1'b0, m_set4 = 1'b0;
  int         m_tick = 0;

  task automatic model_reset();
    m_dly   = '{2'b00, 2'b00};
    m_run   = '{0, 0};
    m_lvl   = 2'b00;
    m_prev0 = 1'b0;
    m_idx   = 0;
    m_rgb0  = 0;
    m_rgb4  = 0;
    m_set0  = 1'b0;
    m_set4  = 1'b0;
    m_tick  = 0;
  endtask

  task automatic model_step(input logic [1:0] raw);
    logic [1:0] s;
    int tgt, nxt, cur, t;
    s   = m_dly[0];
    tgt = m_lvl[1] ? OVR : pal[m_idx];
    if (m_lvl[0] && !m_prev0) m_idx = (m_idx + 1) % N;
    m_prev0 = m_lvl[0];
    for (int b = 0; b < 2; b++) begin
      if (s[b] == m_lvl[b]) m_run[b] = 0;
      else begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b] = s[b];
          m_run[b] = 0;
        end
      end
    end
    void'(m_dly.pop_front());
    m_dly.push_back(raw);
    m_rgb0 = tgt;
    m_set0 = 1'b1;
    if (m_tick % FD == FD - 1) begin
      nxt = 0;
      for (int c = 0; c < 3; c++) begin
        cur = (m_rgb4 >> (8 * c)) & 'hFF;
        t   = (tgt >> (8 * c)) & 'hFF;
        if (cur < t) cur++;
        else if (cur > t) cur--;
        nxt = nxt | (cur << (8 * c));
      end
      m_rgb4 = nxt;
    end
    m_set4 = (m_rgb4 == tgt);
    m_tick++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step(button);
  end

  always @(negedge clk) begin
    check("rgb_step", {8'h0, rgb0}, m_rgb0);
    check("idx_step", {29'h0, idx0}, m_idx);
    check("set_step", {31'h0, set0}, {31'h0, m_set0});
    check("rgb_fade", {8'h0, rgb4}, m_rgb4);
    check("idx_fade", {29'h0, idx4}, m_idx);
    check("set_fade", {31'h0, set4}, {31'h0, m_set4});
  end

  // Called at a falling edge; holds the level for n cycles.
  task automatic drive(input logic [1:0] b, input int n);
    button = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_rgb_step"}, {8'h0, rgb0}, 32'h0);
    check({tag, "_rgb_fade"}, {8'h0, rgb4}, 32'h0);
    check({tag, "_idx"},      {29'h0, idx4}, 32'h0);
    check({tag, "_set"},      {31'h0, set4}, 32'h0);
    button = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rgb", {8'h0, rgb0}, 32'h0);
    check("reset_set", {31'h0, set0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("release_rgb", {8'h0, rgb0}, 32'h3F3F3F);
    check("release_set", {31'h0, set0}, 32'h1);
    check("release_idx", {29'h0, idx0}, 32'h0);
    drive(2'b00, 300);
    check("ramp_idx0", {8'h0, rgb4}, 32'h3F3F3F);

    drive(2'b01, 40); drive(2'b00, 300);
    check("press1_rgb", {8'h0, rgb0}, 32'h7F0000);
    check("press1_idx", {29'h0, idx0}, 32'h1);
    check("fade_end_rgb", {8'h0, rgb4}, 32'h7F0000);
    check("fade_end_set", {31'h0, set4}, 32'h1);
    drive(2'b01, 40); drive(2'b00, 40);
    check("press2_rgb", {8'h0, rgb0}, 32'h007F00);
    drive(2'b01, 40); drive(2'b00, 40);
    check("press3_rgb", {8'h0, rgb0}, 32'h00007F);
    drive(2'b01, 40); drive(2'b00, 40);
    check("press4_rgb", {8'h0, rgb0}, 32'h3F3F3F);
    check("wrap_idx", {29'h0, idx0}, 32'h0);

    drive(2'b01, 10); drive(2'b00, 40);
    check("glitch_idx", {29'h0, idx0}, 32'h0);
    for (int k = 0; k < 5; k++) drive((k % 2 == 0) ? 2'b01 : 2'b00, 3);
    drive(2'b01, 40); drive(2'b00, 40);
    check("bounce_idx", {29'h0, idx0}, 32'h1);
    drive(2'b01, 40); drive(2'b00, 40);
    check("idx2_rgb", {8'h0, rgb0}, 32'h007F00);

    drive(2'b10, 40);
    check("ovr_rgb", {8'h0, rgb0}, 32'h5F5F5F);
    drive(2'b11, 40);
    check("ovr_press_rgb", {8'h0, rgb0}, 32'h5F5F5F);
    check("ovr_press_idx", {29'h0, idx0}, 32'h3);
    drive(2'b10, 40); drive(2'b00, 40);
    check("ovr_release_rgb", {8'h0, rgb0}, 32'h00007F);

    drive(2'b01, 30); drive(2'b00, 20);
    drive(2'b10, 30);
    check("midfade_set", {31'h0, set4}, 32'h0);
    async_reset("midfade_rst");
    drive(2'b00, 30);

    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 24) == 0) async_reset("rand_rst");
      drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
